ext_arbiter: RTL
================

EXT_ARBITER -- requirements
Module: ext_arbiter

Interface
REQ-001 Parameter FAIR, default 1: 1 = round-robin between requesters; 0 = fixed priority, requester 0 wins.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 (decode stage) has an operand.
REQ-005 req0_ready  output  1  requester 0 operand accepted this cycle.
REQ-006 req0_a  input  16  requester 0 immediate.
REQ-007 req0_mode  input  2  requester 0 mode: 00 zero-extend, 01 sign-extend, 10 upper-load, 11 reserved.
REQ-008 req1_valid, req1_ready, req1_a, req1_mode  same directions/widths as REQ-004..007  requester 1 (load unit, halfword data).
REQ-009 out_valid  output  1  out_b/out_id hold a result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 out_b  output  32  extended result.
REQ-012 out_id  output  1  requester that produced out_b.
REQ-013 stall_cnt  output  16  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 The block SHALL share one 16->32 extend datapath between the two requesters, with one output register stage (latency exactly 1 cycle from acceptance to out_valid).
REQ-015 slot_free = !out_valid | out_ready; no request SHALL be accepted when slot_free=0.
REQ-016 Grant when slot_free=1: only one valid -> that one; both valid, FAIR=1 -> requester not granted last; both valid, FAIR=0 -> requester 0.
REQ-017 reqN_ready SHALL be combinational, high only in a cycle where requester N is granted; at most one ready high per cycle.
REQ-018 The round-robin pointer SHALL update only on a grant, to the granted index; no grant leaves it unchanged.
REQ-019 On grant, next cycle: out_valid=1, out_id=granted index, out_b = mode 00 {16'h0000,a}; 01 {{16{a[15]}},a}; 10 per REQ-027; 11 as 00.
REQ-020 slot_free=1 and no valid request: out_valid SHALL go 0 next cycle; out_b/out_id hold last value.
REQ-021 out_valid=1, out_ready=0: out_b, out_id, out_valid SHALL hold stable; both ready outputs low.
REQ-022 out_valid=1, out_ready=1 with a pending request: new result loads the same edge (back-to-back throughput 1 per cycle).
REQ-023 Requester inputs SHALL be sampled only on the grant edge; changes while not granted have no effect.
REQ-024 stall_cnt SHALL increment each cycle out_valid=1 and out_ready=0, saturate at 16'hFFFF, never wrap, and clear only on reset.

Reset
REQ-025 rst=1 SHALL immediately force out_valid=0, out_b=32'h0, out_id=0, stall_cnt=0, round-robin pointer=1 (requester 0 wins first tie), independent of clk.
REQ-026 Reset asserted mid-transfer SHALL discard the held result; reqN_ready SHALL be 0 while rst=1; first grant possible on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro EXT_LUI_EN: defined -> mode 10 yields out_b = {a,16'h0000}; undefined -> mode 10 treated as mode 00 and no shifter logic is synthesized.

Verification
REQ-028 req0 a=16'hAAAA mode 01, out_ready=1 -> req0_ready same cycle; next cycle out_valid=1, out_b=32'hFFFFAAAA, out_id=0.
REQ-029 req1 a=16'hAAAA mode 00 -> out_b=32'h0000AAAA, out_id=1; mode 11 same result.
REQ-030 Both valid continuously, FAIR=1, out_ready=1, after reset -> out_id sequence 0,1,0,1; FAIR=0 -> 0,0,0,0.
REQ-031 out_ready=0 for 5 cycles with result held -> out_b stable, both ready=0, stall_cnt=5; force 70000 stall cycles -> stall_cnt=16'hFFFF.
REQ-032 a=16'h1234 mode 10 -> EXT_LUI_EN defined: 32'h12340000; undefined: 32'h00001234.
REQ-033 Assert rst asynchronously while out_valid=1, out_ready=0 -> out_valid=0, stall_cnt=0 before next clk edge; first tie after release grants requester 0.

Source files
------------

// File: rtl/ext_arbiter.sv
// Shared 16->32 immediate extender arbitrated between decode (req0) and load unit (req1).
// Define EXT_LUI_EN to enable the upper-load mode (mode 10 -> {a,16'h0000}).
module ext_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [1:0]  req0_mode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [1:0]  req1_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_b,
  output logic        out_id,
  output logic [15:0] stall_cnt
);

  // state   | meaning
  // S_EMPTY | output register holds no result; out_b/out_id keep their last value
  // S_FULL  | result presented on out_b/out_id, waiting for out_ready
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_t;

  slot_state_t state, state_nxt;

  logic        slot_free;
  logic        any_valid;
  logic        gnt_vld;
  logic        gnt_idx;
  logic        rr_last;
  logic [15:0] sel_a;
  logic [1:0]  sel_mode;
  logic [31:0] ext_b;

  assign out_valid = (state == S_FULL);
  assign slot_free = !out_valid || out_ready;
  assign any_valid = req0_valid || req1_valid;

  // rr_last is the index granted most recently; a tie goes to the other one
  always_comb begin
    gnt_idx = 1'b0;
    if (req0_valid && req1_valid) begin
      if (FAIR) begin
        gnt_idx = ~rr_last;
      end else begin
        gnt_idx = 1'b0;
      end
    end else if (req1_valid) begin
      gnt_idx = 1'b1;
    end
  end

  assign gnt_vld    = !rst && slot_free && any_valid;
  assign req0_ready = gnt_vld && !gnt_idx;
  assign req1_ready = gnt_vld && gnt_idx;

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: if (gnt_vld) state_nxt = S_FULL;
      S_FULL:  if (out_ready && !gnt_vld) state_nxt = S_EMPTY;
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    sel_a    = gnt_idx ? req1_a : req0_a;
    sel_mode = gnt_idx ? req1_mode : req0_mode;
  end

  // reserved mode 11 (and 10 without upper-load) falls back to zero-extend
  always_comb begin
    ext_b = {16'h0000, sel_a};
    case (sel_mode)
      2'b01:   ext_b = {{16{sel_a[15]}}, sel_a};
`ifdef EXT_LUI_EN
      2'b10:   ext_b = {sel_a, 16'h0000};
`endif
      default: ext_b = {16'h0000, sel_a};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_EMPTY;
      out_b   <= 32'h0000_0000;
      out_id  <= 1'b0;
      rr_last <= 1'b1;
    end else begin
      state <= state_nxt;
      if (gnt_vld) begin
        out_b   <= ext_b;
        out_id  <= gnt_idx;
        rr_last <= gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end

endmodule
